// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: state encoding and default timing shared by the countdown timer.
package countdown_timer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEFAULT_TICKS_PER_SEC = 50_000_000;
endpackage

// File: rtl/countdown_timer_sec_prescaler.sv
// sec_prescaler: clock-cycle down-counter that flags the last cycle of each second while running.
module sec_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int PRESC_WIDTH   = 26
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic terminal
);
    localparam logic [PRESC_WIDTH-1:0] RELOAD = PRESC_WIDTH'(TICKS_PER_SEC - 1);
    logic [PRESC_WIDTH-1:0] count;
    assign terminal = run && (count == '0);
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            count <= RELOAD;
        else if (clear || terminal)
            count <= RELOAD;
        else if (run)
            count <= count - PRESC_WIDTH'(1);
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable seconds countdown with pause, per-second tick and expiry pulse.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC,
    parameter int PRESC_WIDTH   = 26
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] load_value,
    input  logic       enable,
    output logic [4:0] sec_remaining,
    output logic       tick,
    output logic       expired,
    output logic       done
);
    state_t     state, next_state;
    logic [4:0] next_sec;
    logic       next_tick, next_expired, run, terminal;
    // load takes priority, so the prescaler never reports a terminal count on a load cycle
    assign run = (state == RUN) && enable && !load;
    sec_prescaler #(
        .TICKS_PER_SEC(TICKS_PER_SEC),
        .PRESC_WIDTH  (PRESC_WIDTH)
    ) u_presc (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .clear   (load),
        .run     (run),
        .terminal(terminal)
    );
    always_comb begin
        next_state   = state;
        next_sec     = sec_remaining;
        next_tick    = 1'b0;
        next_expired = 1'b0;
        if (load) begin
            next_sec     = load_value;
            next_state   = (load_value != 5'd0) ? RUN : DONE;
            next_expired = (load_value == 5'd0);
        end else if (terminal) begin
            next_tick    = 1'b1;
            next_sec     = (sec_remaining <= 5'd1) ? 5'd0 : sec_remaining - 5'd1;
            next_state   = (sec_remaining <= 5'd1) ? DONE : RUN;
            next_expired = (sec_remaining <= 5'd1);
        end
    end
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sec_remaining <= 5'd0;
            tick          <= 1'b0;
            expired       <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= next_state;
            sec_remaining <= next_sec;
            tick          <= next_tick;
            expired       <= next_expired;
            done          <= (next_state == DONE);
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and random stimulus checked against an elapsed-cycle reference model.
module tb_countdown_timer;
    localparam int T = 4;
    logic       CLOCK_50 = 1'b0;
    logic       reset, load, enable;
    logic [4:0] load_value;
    logic [4:0] sec_remaining;
    logic       tick, expired, done;
    int         vectors = 0;
    int         miscompares = 0;
    int         m_sec, m_el;
    bit         m_run, m_done, m_tick, m_exp;

    countdown_timer #(.TICKS_PER_SEC(T), .PRESC_WIDTH(2)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .load         (load),
        .load_value   (load_value),
        .enable       (enable),
        .sec_remaining(sec_remaining),
        .tick         (tick),
        .expired      (expired),
        .done         (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sec"}, 32'(sec_remaining), 32'(m_sec));
        check({tag, ".tick"}, 32'(tick), 32'(m_tick));
        check({tag, ".expired"}, 32'(expired), 32'(m_exp));
        check({tag, ".done"}, 32'(done), 32'(m_done));
    endtask

    // Model: count enabled cycles since load; every T of them is one second.
    task automatic model_edge(input bit ld, input int val, input bit en);
        m_tick = 0;
        m_exp  = 0;
        if (ld) begin
            m_sec  = val;
            m_el   = 0;
            m_run  = (val != 0);
            m_done = (val == 0);
            m_exp  = (val == 0);
        end else if (m_run && en) begin
            m_el++;
            if (m_el == T) begin
                m_el   = 0;
                m_tick = 1;
                m_sec--;
                if (m_sec == 0) begin
                    m_run  = 0;
                    m_done = 1;
                    m_exp  = 1;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_sec = 0; m_el = 0; m_run = 0; m_done = 0; m_tick = 0; m_exp = 0;
    endtask

    task automatic step(input string tag, input bit ld, input int val, input bit en);
        load       = ld;
        load_value = val[4:0];
        enable     = en;
        @(posedge CLOCK_50);
        model_edge(ld, val, en);
        #1;
        check_all(tag);
    endtask

    task automatic reset_pulse(input string tag);
        reset = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; load_value = 5'd0; enable = 1'b0;
        #3;
        model_reset();
        check_all("reset_state");
        @(posedge CLOCK_50);
        #1;
        reset = 1'b1;
        step("req032_load", 1, 3, 1);
        for (int i = 0; i < 12; i++) step("req032_run", 0, 0, 1);
        check("req032_done_const", 32'(done), 32'd1);
        step("req033_load", 1, 5, 1);
        for (int i = 0; i < 2; i++) step("req033_pre", 0, 0, 1);
        for (int i = 0; i < 10; i++) step("req033_pause", 0, 0, 0);
        for (int i = 0; i < 18; i++) step("req033_resume", 0, 0, 1);
        step("req034_load0", 1, 0, 1);
        check("req034_expired_const", 32'(expired), 32'd1);
        for (int i = 0; i < 3; i++) step("req034_hold", 0, 0, 1);
        step("req037_load1", 1, 1, 1);
        check("req037_done_low", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) step("req037_run", 0, 0, 1);
        check("req037_expired_const", 32'(expired), 32'd1);
        step("req035_load", 1, 3, 1);
        for (int i = 0; i < 7; i++) step("req035_run", 0, 0, 1);
        step("req035_reload", 1, 7, 1);
        check("req035_sec_const", 32'(sec_remaining), 32'd7);
        for (int i = 0; i < 4; i++) step("req035_after", 0, 0, 1);
        step("req036_load", 1, 5, 1);
        for (int i = 0; i < 6; i++) step("req036_run", 0, 0, 1);
        reset_pulse("req036_reset");
        for (int i = 0; i < 8; i++) step("req036_idle", 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) reset_pulse("rand_reset");
            step("rand", $urandom_range(0, 15) == 0, int'($urandom_range(0, 7)), $urandom_range(0, 4) != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
